ff256ct_arbiter_ctrl: RTL
=========================

Name: ff256ct_arbiter_ctrl

Overview:
- Sequences a single shared ff256 cosine-transform datapath between two requesters.
- The datapath is eight row units; each produces one GF(256) output byte from a 64-bit input vector.
- Arbitrates round-robin, drives the core input from a holding register and waits a fixed core latency.
- Captures the 64-bit result and returns it with a requester tag over a valid/ready response channel.

Parameters:
- CORE_LAT, 1, cycles between applying ct_x_o and sampling ct_x_i; legal range 1..15.
- DATA_W, 64, transform vector width (8 bytes); fixed, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req_valid_i  input  2  bit n: requester n presents a vector.
- req_data_i  input  128  [63:0] requester 0 vector, [127:64] requester 1 vector.
- req_ready_o  output  2  bit n: controller accepts requester n this cycle.
- ct_x_o  output  64  vector driven to the transform core.
- ct_x_i  input  64  core result; byte k = row k output.
- rsp_valid_o  output  1  result available.
- rsp_data_o  output  64  captured result; byte k = row k.
- rsp_id_o  output  1  requester that owns rsp_data_o.
- rsp_ready_i  input  1  consumer accepts result.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Port names are clk and reset.
- Reset (reset==0 at an edge): state=IDLE, x_reg=0, res_reg=0, tag=0, last_grant=1, cnt=0.
  - Reset outputs: rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, ct_x_o=0, busy_o=0.
  - req_ready_o is forced to 2'b00 combinationally while reset==0.
- Reset mid-operation: the in-flight transform is discarded and no response is issued.
- FSM states: IDLE, WAIT, DONE.
- IDLE arbitration (combinational grant g):
  - Only one req_valid_i bit set: g = that requester.
  - Both set: g = ~last_grant. First tie after reset goes to requester 0.
  - None set: no grant.
  - req_ready_o = one-hot of g, in IDLE only; 2'b00 in every other state.
- Accept: req_valid_i[g] & req_ready_o[g] at an edge. On accept:
  - x_reg <= selected vector, tag <= g, last_grant <= g.
  - cnt <= CORE_LAT-1; go to WAIT.
- WAIT: ct_x_o = x_reg (x_reg is held in all states). Decrement cnt each cycle.
  - At the edge where cnt==0: res_reg <= ct_x_i; go to DONE.
  - WAIT lasts exactly CORE_LAT cycles.
- DONE: rsp_valid_o=1, rsp_data_o=res_reg, rsp_id_o=tag; all held stable until rsp_ready_i==1.
  - On handshake, go to IDLE; rsp_valid_o drops the next cycle.
  - No new request is accepted in the handshake cycle.
- Latency: accept at edge T, rsp_valid_o high from T+CORE_LAT.
  - Minimum issue interval: CORE_LAT+2 cycles when rsp_ready_i is held high.
- Requesters must hold valid and data until ready. A valid bit dropping in IDLE before acceptance simply re-evaluates the grant.
- rsp_ready_i outside DONE is ignored.
- rsp_data_o and rsp_id_o keep their last values outside DONE.

Optional Feature:
- Macro: FF256CT_ARB_STATS_EN.
- Defined: adds outputs done_cnt0_o[15:0] and done_cnt1_o[15:0].
  - Each counter increments on a DONE handshake for the matching rsp_id_o.
  - Counters wrap 16'hFFFF -> 0 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench core stub for all scenarios: ct_x_i = ~ct_x_o.
- Reset held 3 cycles with req_valid_i=2'b11 -> req_ready_o=00, rsp_valid_o=0, busy_o=0 throughout; first tie after release grants requester 0.
- Single request, CORE_LAT=1, r0 data 64'h0123456789ABCDEF, rsp_ready_i=1:
  - Accept at edge T; rsp_valid_o rises at T+1.
  - rsp_data_o=64'hFEDCBA9876543210, rsp_id_o=0.
  - Back in IDLE at T+2.
- Both valid continuously, r0=64'h11, r1=64'h22, rsp_ready_i=1 -> grants alternate 0,1,0,1; rsp_id_o sequence 0,1,0,1; data ~64'h11, ~64'h22 alternating.
- Backpressure: rsp_ready_i=0 for 5 cycles in DONE -> rsp_valid_o/rsp_data_o/rsp_id_o stable, req_ready_o=00 while r1 waits; r1 granted in the first IDLE cycle after the handshake.
- CORE_LAT=4, change ct_x_i stub value until the final WAIT cycle -> result equals the value sampled at the 4th WAIT edge; rsp_valid_o at T+4.
- Reset asserted during WAIT -> no response, state IDLE, ct_x_o=0. With FF256CT_ARB_STATS_EN: counters 0 after reset and 3/2 after 3 r0 and 2 r1 completions.

Source files
------------

// File: rtl/ff256ct_arbiter_ctrl_if.sv
// Request, core and response signals between the ff256 cosine-transform arbiter and its neighbours.
// The slave modport is the arbiter side; master is the requester/core/consumer side.
interface ff256ct_arbiter_ctrl_if;
   logic [1:0]   req_valid_i;
   logic [127:0] req_data_i;
   logic [1:0]   req_ready_o;
   logic [63:0]  ct_x_o;
   logic [63:0]  ct_x_i;
   logic         rsp_valid_o;
   logic [63:0]  rsp_data_o;
   logic         rsp_id_o;
   logic         rsp_ready_i;
   logic         busy_o;

   modport slave (
      input  req_valid_i, req_data_i, ct_x_i, rsp_ready_i,
      output req_ready_o, ct_x_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
   );

   modport master (
      output req_valid_i, req_data_i, ct_x_i, rsp_ready_i,
      input  req_ready_o, ct_x_o, rsp_valid_o, rsp_data_o, rsp_id_o, busy_o
   );
endinterface

// File: rtl/ff256ct_arbiter_ctrl.sv
// Round-robin sequencer sharing one ff256 cosine-transform core between two requesters.
// Optional completion counters per requester are enabled with FF256CT_ARB_STATS_EN.
module ff256ct_arbiter_ctrl #(
   parameter int CORE_LAT = 1,
   parameter int DATA_W   = 64
) (
   input logic clk,
   input logic reset,
   ff256ct_arbiter_ctrl_if.slave bus
`ifdef FF256CT_ARB_STATS_EN
   ,
   output logic [15:0] done_cnt0_o,
   output logic [15:0] done_cnt1_o
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(CORE_LAT - 1);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] x_reg;
   logic [DATA_W-1:0] res_reg;
   logic              tag;
   logic              rsp_id;
   logic              last_grant;
   logic [3:0]        cnt;

   logic              grant;
   logic              accept;
   logic              capture;
   logic              handshake;
   logic [1:0]        req_ready;

   // Ties alternate against the previous winner; a single requester always wins.
   always_comb begin
      state_next = state;
      req_ready  = 2'b00;
      accept     = 1'b0;
      capture    = 1'b0;
      handshake  = 1'b0;
      grant      = (bus.req_valid_i == 2'b11) ? ~last_grant : bus.req_valid_i[1];
      case (state)
         IDLE: begin
            if (reset && (bus.req_valid_i != 2'b00)) begin
               req_ready  = grant ? 2'b10 : 2'b01;
               accept     = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               capture    = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.rsp_ready_i) begin
               handshake  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Holding registers: the core input is held in every state, the result only
   // changes when a WAIT period completes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         x_reg      <= '0;
         res_reg    <= '0;
         tag        <= 1'b0;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= 4'd0;
      end else begin
         state <= state_next;
         if (accept) begin
            x_reg      <= grant ? bus.req_data_i[127:64] : bus.req_data_i[63:0];
            tag        <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
         end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= 4'(cnt - 4'd1);
         end
         if (capture) begin
            res_reg <= bus.ct_x_i;
            rsp_id  <= tag;
         end
      end
   end

`ifdef FF256CT_ARB_STATS_EN
   // Completed responses per requester, free-running and wrapping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         done_cnt0_o <= 16'd0;
         done_cnt1_o <= 16'd0;
      end else if (handshake) begin
         if (rsp_id) done_cnt1_o <= 16'(done_cnt1_o + 16'd1);
         else        done_cnt0_o <= 16'(done_cnt0_o + 16'd1);
      end
   end
`endif

   assign bus.req_ready_o = req_ready;
   assign bus.ct_x_o      = x_reg;
   assign bus.rsp_valid_o = (state == DONE);
   assign bus.rsp_data_o  = res_reg;
   assign bus.rsp_id_o    = rsp_id;
   assign bus.busy_o      = (state != IDLE);

endmodule
